// File: rtl/stack_multi_if.sv
// Command/response bundle for stack_multi: the op request from the interpreter
// core and the stack's registered results, status and sticky error flags.
interface stack_multi_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int STACKS = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STACKS);

  logic              op_en;
  logic [2:0]        op;
  logic [SW-1:0]     sel;
  logic [AW:0]       index;
  logic [WIDTH-1:0]  data_in;
  logic              err_clr;
  logic [WIDTH-1:0]  data_out;
  logic              out_valid;
  logic [AW:0]       depth;
  logic              full;
  logic              empty;
  logic              err;
  logic [STACKS-1:0] ovf;
  logic [STACKS-1:0] unf;

  modport master (
    output op_en, op, sel, index, data_in, err_clr,
    input  data_out, out_valid, depth, full, empty, err, ovf, unf
  );

  modport slave (
    input  op_en, op, sel, index, data_in, err_clr,
    output data_out, out_valid, depth, full, empty, err, ovf, unf
  );
endinterface

// File: rtl/stack_multi.sv
// STACKS independent LIFO stacks sharing one synchronous-read RAM addressed as
// {sel, slot}; per-stack pointers, registered read data and sticky error flags.
module stack_multi #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int STACKS = 4
) (
  input logic         clk,
  input logic         rst,
  stack_multi_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STACKS);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   PTR_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] SLOT_ONE = AW'(1);

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_PEEK, OP_POKE, OP_REPLACE, OP_CLEAR, OP_RSVD
  } op_e;

  logic [WIDTH-1:0]  mem [STACKS*DEPTH];
  logic [AW:0]       ptr [STACKS];
  logic [WIDTH-1:0]  data_out_q;
  logic              out_valid_q;
  logic              err_q;
  logic [STACKS-1:0] ovf_q;
  logic [STACKS-1:0] unf_q;

  op_e               op_dec;
  logic [AW:0]       cur_ptr;
  logic              is_full;
  logic              is_empty;
  logic              idx_ok;
  logic [AW-1:0]     top_slot;
  logic [AW-1:0]     idx_slot;
  logic [AW-1:0]     slot;
  logic [SW+AW-1:0]  addr;
  logic              do_write;
  logic              do_read;
  logic              reject;
  logic              ptr_we;
  logic [AW:0]       ptr_next;
  logic [STACKS-1:0] ovf_set;
  logic [STACKS-1:0] unf_set;

  assign op_dec   = op_e'(bus.op);
  assign cur_ptr  = ptr[bus.sel];
  assign is_full  = (cur_ptr == PTR_FULL);
  assign is_empty = (cur_ptr == '0);
  assign idx_ok   = (bus.index < cur_ptr);
  // Slot arithmetic wraps modulo DEPTH; it is only used when ptr/index are in range.
  assign top_slot = cur_ptr[AW-1:0] - SLOT_ONE;
  assign idx_slot = cur_ptr[AW-1:0] - SLOT_ONE - bus.index[AW-1:0];
  assign addr     = {bus.sel, slot};

  always_comb begin
    do_write = 1'b0;
    do_read  = 1'b0;
    reject   = 1'b0;
    ptr_we   = 1'b0;
    ptr_next = cur_ptr;
    slot     = top_slot;
    ovf_set  = '0;
    unf_set  = '0;
    if (bus.op_en && !rst) begin
      case (op_dec)
        OP_PUSH: begin
          if (is_full) begin
            reject           = 1'b1;
            ovf_set[bus.sel] = 1'b1;
          end else begin
            do_write = 1'b1;
            slot     = cur_ptr[AW-1:0];
            ptr_we   = 1'b1;
            ptr_next = cur_ptr + PTR_ONE;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            reject           = 1'b1;
            unf_set[bus.sel] = 1'b1;
          end else begin
            do_read  = 1'b1;
            ptr_we   = 1'b1;
            ptr_next = cur_ptr - PTR_ONE;
          end
        end
        OP_PEEK, OP_POKE: begin
          slot = idx_slot;
          if (!idx_ok) begin
            reject           = 1'b1;
            unf_set[bus.sel] = 1'b1;
          end else if (op_dec == OP_PEEK) begin
            do_read = 1'b1;
          end else begin
            do_write = 1'b1;
          end
        end
        OP_REPLACE: begin
          if (is_empty) begin
            reject           = 1'b1;
            unf_set[bus.sel] = 1'b1;
          end else begin
            do_read  = 1'b1;
            do_write = 1'b1;
          end
        end
        OP_CLEAR: begin
          ptr_we   = 1'b1;
          ptr_next = '0;
        end
        default: ;
      endcase
    end
  end

  // RAM contents survive reset; only the write port lives here.
  always_ff @(posedge clk) begin
    if (do_write) mem[addr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STACKS; s++) ptr[s] <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= '0;
      unf_q       <= '0;
    end else begin
      if (ptr_we) ptr[bus.sel] <= ptr_next;
      // Reading with NBA semantics returns the old word on REPLACE's same-slot write.
      if (do_read) data_out_q <= mem[addr];
      out_valid_q <= do_read;
      err_q       <= reject;
      ovf_q       <= (bus.err_clr ? '0 : ovf_q) | ovf_set;
      unf_q       <= (bus.err_clr ? '0 : unf_q) | unf_set;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.depth     = cur_ptr;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.err       = err_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
endmodule

// File: tb/tb_stack_multi.sv
// Directed self-checking bench for stack_multi: push/pop ordering, full/empty
// boundaries, peek/poke/replace, sticky flags, clear and mid-stream reset.
module tb_stack_multi;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 256;
  localparam int STACKS = 4;
  localparam int AW     = $clog2(DEPTH);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, PEEK = 3'd3;
  localparam logic [2:0] POKE = 3'd4, REPLACE = 3'd5, CLEAR = 3'd6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  stack_multi_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STACKS(STACKS)) bus ();

  stack_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STACKS(STACKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One op per call; returns 1 ns after the executing edge so registered results are visible.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] sel,
                               input logic [AW:0] idx, input logic [WIDTH-1:0] data);
    bus.op_en   = 1'b1;
    bus.op      = op;
    bus.sel     = sel;
    bus.index   = idx;
    bus.data_in = data;
    @(posedge clk);
    #1;
    bus.op_en = 1'b0;
    bus.op    = NOP;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.op_en   = 1'b0;
    bus.op      = NOP;
    bus.sel     = '0;
    bus.index   = '0;
    bus.data_in = '0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_depth", 32'(bus.depth), 0);
    checkOutput("rst_empty", 32'(bus.empty), 1);
    checkOutput("rst_full", 32'(bus.full), 0);
    checkOutput("rst_dout", 32'(bus.data_out), 0);
    checkOutput("rst_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_err", 32'(bus.err), 0);
    checkOutput("rst_ovf", 32'(bus.ovf), 0);
    checkOutput("rst_unf", 32'(bus.unf), 0);

    $display("[TB] push/pop ordering on s0");
    applyStimulus(PUSH, 2'd0, '0, 8'h11);
    applyStimulus(PUSH, 2'd0, '0, 8'h22);
    applyStimulus(PUSH, 2'd0, '0, 8'h33);
    checkOutput("s0_depth3", 32'(bus.depth), 3);
    checkOutput("push_no_valid", 32'(bus.out_valid), 0);
    applyStimulus(POP, 2'd0, '0, 8'h00);
    checkOutput("pop1_valid", 32'(bus.out_valid), 1);
    checkOutput("pop1_data", 32'(bus.data_out), 32'h33);
    applyStimulus(POP, 2'd0, '0, 8'h00);
    checkOutput("pop2_data", 32'(bus.data_out), 32'h22);
    applyStimulus(POP, 2'd0, '0, 8'h00);
    checkOutput("pop3_data", 32'(bus.data_out), 32'h11);
    checkOutput("s0_empty", 32'(bus.empty), 1);
    applyStimulus(NOP, 2'd0, '0, 8'h00);
    checkOutput("idle_valid", 32'(bus.out_valid), 0);
    checkOutput("idle_hold", 32'(bus.data_out), 32'h11);

    $display("[TB] fill s1 to full");
    for (int i = 0; i < DEPTH; i++) applyStimulus(PUSH, 2'd1, '0, 8'(i));
    checkOutput("s1_full", 32'(bus.full), 1);
    checkOutput("s1_depth_full", 32'(bus.depth), DEPTH);
    checkOutput("fill_no_err", 32'(bus.err), 0);
    applyStimulus(PUSH, 2'd1, '0, 8'hEE);
    checkOutput("ovf_err", 32'(bus.err), 1);
    checkOutput("ovf_flag", 32'(bus.ovf), 32'b0010);
    checkOutput("ovf_depth", 32'(bus.depth), DEPTH);
    applyStimulus(PEEK, 2'd1, '0, 8'h00);
    checkOutput("err_pulse_end", 32'(bus.err), 0);
    checkOutput("full_top_kept", 32'(bus.data_out), 32'hFF);

    $display("[TB] underflow and err_clr");
    applyStimulus(POP, 2'd2, '0, 8'h00);
    checkOutput("unf_err", 32'(bus.err), 1);
    checkOutput("unf_no_valid", 32'(bus.out_valid), 0);
    checkOutput("unf_flag", 32'(bus.unf), 32'b0100);
    checkOutput("unf_depth", 32'(bus.depth), 0);
    bus.err_clr = 1'b1;
    applyStimulus(NOP, 2'd2, '0, 8'h00);
    bus.err_clr = 1'b0;
    checkOutput("clr_unf", 32'(bus.unf), 0);
    checkOutput("clr_ovf", 32'(bus.ovf), 0);
    bus.err_clr = 1'b1;
    applyStimulus(PUSH, 2'd1, '0, 8'hEE);
    bus.err_clr = 1'b0;
    checkOutput("clr_vs_new_ovf", 32'(bus.ovf), 32'b0010);
    bus.err_clr = 1'b1;
    applyStimulus(NOP, 2'd1, '0, 8'h00);
    bus.err_clr = 1'b0;
    checkOutput("clr_again", 32'(bus.ovf), 0);

    $display("[TB] peek/poke on s0");
    applyStimulus(PUSH, 2'd0, '0, 8'hA1);
    applyStimulus(PUSH, 2'd0, '0, 8'hB2);
    applyStimulus(PUSH, 2'd0, '0, 8'hC3);
    applyStimulus(PEEK, 2'd0, 9'd2, 8'h00);
    checkOutput("peek2_data", 32'(bus.data_out), 32'hA1);
    checkOutput("peek2_valid", 32'(bus.out_valid), 1);
    checkOutput("peek_depth", 32'(bus.depth), 3);
    applyStimulus(POKE, 2'd0, 9'd1, 8'h5A);
    checkOutput("poke_no_valid", 32'(bus.out_valid), 0);
    checkOutput("poke_no_err", 32'(bus.err), 0);
    applyStimulus(PEEK, 2'd0, 9'd1, 8'h00);
    checkOutput("peek1_data", 32'(bus.data_out), 32'h5A);
    applyStimulus(PEEK, 2'd0, 9'd0, 8'h00);
    checkOutput("peek0_data", 32'(bus.data_out), 32'hC3);
    applyStimulus(PEEK, 2'd0, 9'd3, 8'h00);
    checkOutput("peek3_err", 32'(bus.err), 1);
    checkOutput("peek3_no_valid", 32'(bus.out_valid), 0);
    checkOutput("peek3_unf", 32'(bus.unf), 32'b0001);
    applyStimulus(POKE, 2'd0, 9'd3, 8'hEE);
    checkOutput("poke3_err", 32'(bus.err), 1);
    applyStimulus(PEEK, 2'd0, 9'd2, 8'h00);
    checkOutput("poke3_no_write", 32'(bus.data_out), 32'hA1);

    $display("[TB] replace on s3");
    applyStimulus(PUSH, 2'd3, '0, 8'h44);
    applyStimulus(REPLACE, 2'd3, '0, 8'h99);
    checkOutput("repl_data", 32'(bus.data_out), 32'h44);
    checkOutput("repl_valid", 32'(bus.out_valid), 1);
    checkOutput("repl_depth", 32'(bus.depth), 1);
    applyStimulus(POP, 2'd3, '0, 8'h00);
    checkOutput("repl_pop", 32'(bus.data_out), 32'h99);
    applyStimulus(REPLACE, 2'd3, '0, 8'h12);
    checkOutput("repl_empty_err", 32'(bus.err), 1);
    checkOutput("repl_empty_unf", 32'(bus.unf), 32'b1001);

    $display("[TB] interleave, clear, mid-stream reset");
    applyStimulus(CLEAR, 2'd1, '0, 8'h00);
    checkOutput("clear_s1", 32'(bus.depth), 0);
    checkOutput("clear_no_err", 32'(bus.err), 0);
    applyStimulus(PUSH, 2'd0, '0, 8'h10);
    applyStimulus(PUSH, 2'd1, '0, 8'h20);
    applyStimulus(PUSH, 2'd0, '0, 8'h11);
    applyStimulus(PUSH, 2'd1, '0, 8'h21);
    checkOutput("s1_depth2", 32'(bus.depth), 2);
    bus.sel = 2'd0;
    #1;
    checkOutput("s0_depth5", 32'(bus.depth), 5);
    applyStimulus(CLEAR, 2'd0, '0, 8'h00);
    checkOutput("s0_cleared", 32'(bus.empty), 1);
    bus.sel = 2'd1;
    #1;
    checkOutput("s1_intact", 32'(bus.depth), 2);
    applyStimulus(POP, 2'd1, '0, 8'h00);
    checkOutput("s1_pop", 32'(bus.data_out), 32'h21);

    rst         = 1'b1;
    bus.op_en   = 1'b1;
    bus.op      = PUSH;
    bus.sel     = 2'd1;
    bus.data_in = 8'h77;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.op_en = 1'b0;
    bus.op    = NOP;
    checkOutput("mid_rst_dout", 32'(bus.data_out), 0);
    checkOutput("mid_rst_unf", 32'(bus.unf), 0);
    for (int s = 0; s < STACKS; s++) begin
      bus.sel = 2'(s);
      #1;
      checkOutput($sformatf("mid_rst_depth_s%0d", s), 32'(bus.depth), 0);
    end
    applyStimulus(PUSH, 2'd1, '0, 8'h55);
    applyStimulus(POP, 2'd1, '0, 8'h00);
    checkOutput("post_rst_pop", 32'(bus.data_out), 32'h55);
    checkOutput("post_rst_empty", 32'(bus.empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
